// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline memory-bus types for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_BE_W-1:0]   be;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } mem_req_t;

    // Fetches are always full-word reads.
    function automatic mem_req_t fetch_req(input logic [BUS_ADDR_W-1:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.be    = '1;
        r.addr  = addr;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants made while a fetch waits; flags when fetch must win.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_grant,
    input  logic d_grant,
    input  logic if_pending,
    output logic override_c
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] count_q;

    // Count consecutive data wins against a waiting fetch, clear otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (if_grant) begin
            count_q <= '0;
        end else if (d_grant) begin
            if (!if_pending) begin
                count_q <= '0;
            end else if (count_q != CNT_W'(STARVE_LIMIT)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign override_c = (count_q == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and MEM-stage data.
// Optional: define ARB_PERF_CNT_EN for grant / stall performance counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_d_grants,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    logic       killed_q, killed_d;
    mem_req_t   req_q, req_d;
    logic       mem_req_q;
    logic       grant_if, grant_d;
    logic       want_if;
    logic       override_c;
    logic       resp_fire;

    assign want_if = if_req & ~if_kill;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_grant   (grant_if),
        .d_grant    (grant_d),
        .if_pending (want_if),
        .override_c (override_c)
    );

    // Next-state, arbitration and request latching.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        killed_d = killed_q;
        req_d    = req_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                grant_if = want_if && (!d_req || override_c);
                grant_d  = d_req && !grant_if;
                if (grant_if) begin
                    owner_d = OWN_IF;
                    req_d   = fetch_req(BUS_ADDR_W'(if_addr));
                    state_d = REQ;
                end else if (grant_d) begin
                    owner_d     = OWN_D;
                    req_d.we    = d_we;
                    req_d.be    = BUS_BE_W'(d_be);
                    req_d.addr  = BUS_ADDR_W'(d_addr);
                    req_d.wdata = BUS_DATA_W'(d_wdata);
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (owner_q == OWN_IF && if_kill) begin
                    killed_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_IF && if_kill) begin
                    killed_d = 1'b1;
                end
                if (mem_rvalid) begin
                    killed_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner, kill flag, latched request and the bus request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            killed_q  <= 1'b0;
            req_q     <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            killed_q  <= killed_d;
            req_q     <= req_d;
            mem_req_q <= (state_d == REQ);
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_be    = BE_W'(req_q.be);
    assign mem_addr  = ADDR_W'(req_q.addr);
    assign mem_wdata = DATA_W'(req_q.wdata);

    // Responses are forwarded in the cycle they arrive; stray pulses outside RESP are dropped.
    assign resp_fire = (state_q == RESP) && mem_rvalid;
    assign d_rvalid  = resp_fire && (owner_q == OWN_D);
    assign if_rvalid = resp_fire && (owner_q == OWN_IF) && !killed_q && !if_kill;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;

    assign if_stall = if_req & ~if_rvalid & ~if_kill;
    assign d_stall  = d_req & ~d_rvalid;

`ifdef ARB_PERF_CNT_EN
    // Wrapping grant and stall-cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_grants    <= '0;
            perf_d_grants     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (grant_if) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (grant_d) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (if_stall || d_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
